// File: rtl/uart_tx_drain.sv
// Serial transmit stage that drains a byte FIFO into 8-bit UART frames (start, LSB-first data, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_drain #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned       BAUD_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              busy_q, busy_d;
  logic              tx_done_q, tx_done_d;
  logic              bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Next-state, bit timing and shift-register datapath
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    bit_end_s = (baud_q == BAUD_MAX);

    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // Registered FIFO data is valid now, one cycle after the strobe
        shift_d = fifo_dout;
        bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
        par_d   = even_parity(fifo_dout);
`endif
        state_d = S_START;
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || state_q == S_FETCH || state_q == S_LOAD) begin
      baud_d = {BAUD_W{1'b0}};
    end else if (bit_end_s) begin
      baud_d = {BAUD_W{1'b0}};
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  // Output values for the coming cycle, derived from the next state so the outputs can be flopped
  always_comb begin
    fifo_rd_d = (state_d == S_FETCH);
    busy_d    = (state_d != S_IDLE);
    tx_done_d = (state_d == S_STOP) && (baud_d == BAUD_MAX);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= {BAUD_W{1'b0}};
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign fifo_rd = fifo_rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench for uart_tx_drain: a FIFO model feeds a CLK_DIV=4 instance whose frames are decoded
// and compared against queued bytes; a CLK_DIV=2 instance is checked cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CD4 = 4;
  localparam int CD2 = 2;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       enable      = 1'b0;
  logic       fifo_empty4 = 1'b1;
  logic [7:0] fifo_dout4  = 8'h00;
  logic       fifo_rd4, tx4, busy4, tx_done4;
  logic       fifo_empty2 = 1'b1;
  logic [7:0] fifo_dout2  = 8'h00;
  logic       fifo_rd2, tx2, busy2, tx_done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int          cyc        = 0;
  int          rd_cnt     = 0;
  int          rd_cyc     = -100;
  int          rd2_cnt    = 0;
  int          frames     = 0;
  int          last_gap   = -1;
  logic        m_active   = 1'b0;
  logic        m_have_prev = 1'b0;
  int          m_cyc      = 0;
  int          m_glitch   = 0;
  int          m_stop_cyc = 0;
  logic [10:0] m_bits     = 11'd0;

  uart_tx_drain #(.CLK_DIV(CD4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty4),
    .fifo_dout(fifo_dout4), .fifo_rd(fifo_rd4), .tx(tx4), .busy(busy4), .tx_done(tx_done4)
  );

  uart_tx_drain #(.CLK_DIV(CD2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty2),
    .fifo_dout(fifo_dout2), .fifo_rd(fifo_rd2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  // Registered-output FIFO model: data and empty flag update on the edge that ends the read cycle
  always @(posedge clk) begin
    if (fifo_rd4 === 1'b1 && fifo_q.size() > 0) fifo_dout4 <= fifo_q.pop_front();
    fifo_empty4 <= (fifo_q.size() == 0);
  end

  // Frame decoder and scoreboard for the CLK_DIV=4 instance
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_rd2 === 1'b1) rd2_cnt++;
    if (fifo_rd4 === 1'b1) begin
      rd_cnt++;
      rd_cyc = cyc;
      check_eq("rd_while_nonempty", fifo_empty4, 1'b0);
      check_eq("busy_at_fetch", busy4, 1'b1);
    end
    if (rst_n !== 1'b1) begin
      // byte already read but cut off by reset is lost
      if (m_active && exp_q.size() > 0) void'(exp_q.pop_front());
      m_active = 1'b0;
    end else begin
      if (!m_active && tx4 === 1'b0) begin
        m_active = 1'b1;
        m_cyc    = 0;
        m_glitch = 0;
        check_eq("rd_to_start", cyc - rd_cyc, 2);
        if (m_have_prev) last_gap = cyc - m_stop_cyc - 1;
      end
      if (m_active) begin
        if (m_cyc % CD4 == 0) m_bits[m_cyc / CD4] = tx4;
        else if (tx4 !== m_bits[m_cyc / CD4]) m_glitch++;
        check_eq("busy_in_frame", busy4, 1'b1);
        check_eq("tx_done_pos", tx_done4, (m_cyc == NB * CD4 - 1));
        if (m_cyc == NB * CD4 - 1) begin
          logic [7:0] want;
          check_eq("sb_nonempty", (exp_q.size() != 0), 1'b1);
          want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          check_eq("start_bit", m_bits[0], 1'b0);
          check_eq("data_byte", m_bits[8:1], want);
`ifdef UART_TX_PARITY_EN
          check_eq("parity_bit", m_bits[9], ^want);
`endif
          check_eq("stop_bit", m_bits[NB-1], 1'b1);
          check_eq("bit_stable", m_glitch, 0);
          m_active    = 1'b0;
          m_stop_cyc  = cyc;
          m_have_prev = 1'b1;
          frames++;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input string tag, input int n);
    int target;
    target = frames + n;
    for (int i = 0; i < 3000 && frames < target; i++) tick();
    check_eq(tag, frames, target);
  endtask

  task automatic wait_mcyc(input string tag, input int c);
    for (int i = 0; i < 3000 && !(m_active && m_cyc == c); i++) tick();
    check_eq(tag, (m_active && m_cyc == c), 1'b1);
  endtask

  initial begin
    int         rd_base;
    logic [7:0] b2;
    logic [10:0] f2;

    // Reset state
    repeat (3) tick();
    check_eq("rst_outputs4", {tx4, busy4, fifo_rd4, tx_done4}, 4'b1000);
    check_eq("rst_outputs2", {tx2, busy2, fifo_rd2, tx_done2}, 4'b1000);
    rst_n = 1'b1;
    tick();

    // Empty FIFO with enable held high: nothing moves
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("empty_idle", {tx4, busy4, fifo_rd4, tx_done4}, 4'b1000);
    end

    // Single byte
    rd_base = rd_cnt;
    push4(8'hA5);
    wait_frames("frame_a5", 1);
    check_eq("rd_count_a5", rd_cnt - rd_base, 1);
    tick();
    check_eq("busy_fall_a5", busy4, 1'b0);

    // Two bytes back to back
    rd_base = rd_cnt;
    push4(8'h00);
    push4(8'hFF);
    wait_frames("frames_00_ff", 2);
    check_eq("rd_count_pair", rd_cnt - rd_base, 2);
    check_eq("b2b_gap", last_gap, 3);
    repeat (5) tick();

    // Drop enable during data bit 3 with bytes queued
    rd_base = rd_cnt;
    push4(8'h3C);
    push4(8'h5A);
    push4(8'h99);
    wait_mcyc("reach_data3", (1 + 3) * CD4 + 1);
    enable = 1'b0;
    wait_frames("frame_en_drop", 1);
    repeat (30) tick();
    check_eq("rd_hold_en_off", rd_cnt - rd_base, 1);
    check_eq("fifo_left", fifo_q.size(), 2);
    check_eq("busy_en_off", busy4, 1'b0);
    enable = 1'b1;
    wait_frames("frames_en_back", 2);
    check_eq("rd_count_en", rd_cnt - rd_base, 3);
    repeat (5) tick();

    // Async reset during data bit 5
    push4(8'hC3);
    push4(8'h7E);
    wait_mcyc("reach_data5", (1 + 5) * CD4 + 2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_tx_high", tx4, 1'b1);
    check_eq("rst_busy_low", busy4, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rd_after_rst", fifo_rd4, 1'b1);
    wait_frames("frame_after_rst", 1);
    repeat (5) tick();

    // CLK_DIV=2 instance, byte 0x81
    b2 = 8'h81;
`ifdef UART_TX_PARITY_EN
    f2 = {1'b1, ^b2, b2, 1'b0};
`else
    f2 = {1'b0, 1'b1, b2, 1'b0};
`endif
    fifo_dout2  = b2;
    fifo_empty2 = 1'b0;
    for (int i = 0; i < 20 && fifo_rd2 !== 1'b1; i++) tick();
    check_eq("rd2_seen", fifo_rd2, 1'b1);
    fifo_empty2 = 1'b1;
    tick();
    check_eq("load2_tx", {tx2, busy2}, 2'b11);
    for (int k = 0; k < NB * CD2; k++) begin
      tick();
      check_eq("cd2_tx", tx2, f2[k / CD2]);
      check_eq("cd2_tx_done", tx_done2, (k == NB * CD2 - 1));
    end
    tick();
    check_eq("cd2_idle", {tx2, busy2}, 2'b10);
    check_eq("cd2_rd_count", rd2_cnt, 1);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmit stage that drains the byte FIFO and emits each byte as an 8-bit asynchronous UART frame: start bit, data LSB first, optional parity, one stop bit. It sits directly downstream of the FIFO. It watches the FIFO's empty flag, issues one-cycle read strobes, captures the FIFO's registered read data, and serialises it on `tx` at a fixed bit period of `CLK_DIV` clocks.

## Interface
- `CLK_DIV`, default 16: clocks per bit period; legal range 2..65535.
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `enable` input, 1 bit: permits starting new frames; does not abort a frame in progress.
- `fifo_empty` input, 1 bit: FIFO empty flag.
- `fifo_dout` input, 8 bits: FIFO read data; valid the cycle after `fifo_rd`.
- `fifo_rd` output, 1 bit: registered read strobe to the FIFO; exactly one clk wide per byte.
- `tx` output, 1 bit: serial line, idles high.
- `busy` output, 1 bit: high in every state except IDLE.
- `tx_done` output, 1 bit: one-clk pulse on the last cycle of each stop bit.

## Operation
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, state=IDLE, shift register=0, bit counter=0, baud counter=0.
- FSM states and transitions:
  - IDLE → FETCH when `enable`=1 and `fifo_empty`=0.
  - FETCH → LOAD.
  - LOAD → START.
  - START → DATA.
  - DATA → PARITY (macro defined) or STOP, after bit 7.
  - PARITY → STOP.
  - STOP → IDLE.
- FETCH: `fifo_rd`=1 for this single cycle. The strobe is never issued while `fifo_empty`=1.
- LOAD: `fifo_dout` is captured into an 8-bit shift register at the end of this cycle. `tx` stays high.
- START: `tx`=0 for `CLK_DIV` clocks.
- DATA: `tx` = shift register bit 0 for `CLK_DIV` clocks per bit. The register shifts right after each bit. The 3-bit bit counter counts 0..7.
- STOP: `tx`=1 for `CLK_DIV` clocks. `tx_done`=1 on the final clock of STOP.
- Baud counter: width `$clog2(CLK_DIV)`, counts 0..`CLK_DIV`-1 and wraps to 0 on bit advance. It is held at 0 in IDLE, FETCH and LOAD.
- `enable` dropped mid-frame: the frame completes normally. IDLE then holds with no further `fifo_rd`.
- `fifo_empty` changing during a frame: ignored. It is sampled only in IDLE.
- Async reset mid-frame: `tx` returns high immediately and the FSM goes to IDLE. The partially sent byte is lost and not re-read.

## Timing
- Call the `fifo_rd` cycle T.
- Data capture occurs at the end of T+1. `tx` falls at T+2.
- Frame length: 10×`CLK_DIV` clocks, or 11×`CLK_DIV` with parity.
- Back-to-back frames: the STOP → IDLE → FETCH → LOAD path gives 3 idle-high clocks between a stop bit's end and the next start bit. Steady-state period is (10×`CLK_DIV`)+3 clocks.
- `busy` rises in FETCH (T) and falls on entry to IDLE, the clock after the `tx_done` pulse.
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- `UART_TX_PARITY_EN`, defined: the PARITY state is compiled in. `tx` = even parity (XOR of the 8 data bits) for `CLK_DIV` clocks between bit 7 and the stop bit.
- `UART_TX_PARITY_EN`, undefined: the PARITY state and parity logic are absent. DATA goes directly to STOP.

## Test plan
- Single byte, `CLK_DIV`=4, FIFO holds 0xA5, `enable`=1:
  - one `fifo_rd` pulse;
  - `tx` per 4-clk bit = 0,1,0,1,0,0,1,0,1,1;
  - `tx_done` at clock 40 after `tx` falls;
  - with macro, parity bit 0 is inserted before stop.
- Two bytes 0x00 and 0xFF back-to-back, `CLK_DIV`=4:
  - exactly two `fifo_rd` pulses;
  - second start bit begins 3 clocks after the first stop bit ends;
  - with macro, parity bits are 0 then 0.
- `fifo_empty`=1 held for 100 clocks with `enable`=1: `fifo_rd`, `busy` and `tx_done` stay 0; `tx` stays 1.
- `enable` deasserted during data bit 3 with bytes still queued: the current frame completes with correct bits, then no further `fifo_rd` until `enable` returns.
- `rst_n` pulsed low during data bit 5:
  - `tx`=1 and `busy`=0 immediately;
  - after release with the FIFO non-empty, the next `fifo_rd` occurs on the first clock edge where IDLE sees `enable`=1 and `fifo_empty`=0.
- `CLK_DIV`=2, byte 0x81: each bit is held exactly 2 clocks, data = 1,0,0,0,0,0,0,1, and the frame spans 20 clocks (22 with macro, parity 0).
